// File: rtl/symbol_upsampler.sv
// Symbol-to-sample upsampler for the transmit path.
// Takes I/Q symbols over a valid/ready handshake and produces one sample per
// clock. A phase accumulator marks symbol boundaries: it advances by STEP every
// cycle and fires when it reaches the current period. The period can be pulled
// off nominal by RATE_OFFSET, which produces a deliberate symbol-rate error.
module symbol_upsampler #(
  parameter int WIDTH    = 16,
  parameter int OSR_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    ZERO_STUFF,
  input  logic signed [WIDTH-1:0] RATE_OFFSET,
  input  logic                    clr_underflow,
  input  logic signed [WIDTH-1:0] I_1M,
  input  logic signed [WIDTH-1:0] Q_1M,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic signed [WIDTH-1:0] I_32M,
  output logic signed [WIDTH-1:0] Q_32M,
  output logic                    sym_strobe,
  output logic                    underflow
);

  // Accumulator and period carry one extra bit so the clamped maximum period
  // plus one step never wraps.
  localparam int CW = WIDTH + 1;
  localparam logic [CW-1:0] PERIOD_NOM = CW'(1) << (WIDTH - 3);
  localparam logic [CW-1:0] STEP       = PERIOD_NOM >> OSR_LOG2;
  localparam logic [CW-1:0] PERIOD_MIN = PERIOD_NOM >> 1;
  localparam logic [CW-1:0] PERIOD_MAX = PERIOD_NOM + (PERIOD_NOM >> 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   run;

  logic [CW-1:0] cnt;
  logic [CW-1:0] period;

  logic                    buf_full;
  logic signed [WIDTH-1:0] buf_i;
  logic signed [WIDTH-1:0] buf_q;

  logic signed [WIDTH-1:0] sym_i_p0;
  logic signed [WIDTH-1:0] sym_q_p0;

  logic                    accept;
  logic                    boundary;
  logic                    uf_set;
  logic signed [WIDTH-1:0] load_i;
  logic signed [WIDTH-1:0] load_q;

  // Nominal period plus a signed offset, saturated to half..one-and-a-half
  // of nominal so a wild offset cannot stall or race the symbol clock.
  function automatic logic [CW-1:0] clamp_period(input logic signed [WIDTH-1:0] offset);
    logic signed [WIDTH+1:0] sum;
    sum = $signed({1'b0, PERIOD_NOM}) + $signed({{2{offset[WIDTH-1]}}, offset});
    if (sum < $signed({1'b0, PERIOD_MIN})) begin
      return PERIOD_MIN;
    end
    if (sum > $signed({1'b0, PERIOD_MAX})) begin
      return PERIOD_MAX;
    end
    return sum[CW-1:0];
  endfunction

  assign sym_ready = !buf_full && !rst;
  assign accept    = sym_valid && sym_ready;

  // Mode decision: the datapath acts on the mode chosen for the current cycle,
  // so enabling gives a boundary in the same cycle and disabling zeroes the
  // outputs on the very next edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en)  state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    run = (state_next == RUN);
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign boundary = run && (cnt >= period);

  // Source of the next symbol at a boundary: buffered symbol first, then a
  // same-cycle accept bypassing the buffer, otherwise a zero (underflow).
  always_comb begin
    load_i = '0;
    load_q = '0;
    uf_set = 1'b0;
    if (buf_full) begin
      load_i = buf_i;
      load_q = buf_q;
    end else if (accept) begin
      load_i = I_1M;
      load_q = Q_1M;
    end else begin
      uf_set = boundary;
    end
  end

  // Phase accumulator; the period for the next symbol is latched at each boundary.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt    <= PERIOD_NOM;
      period <= PERIOD_NOM;
    end else if (boundary) begin
      cnt    <= cnt - period + STEP;
      period <= clamp_period(RATE_OFFSET);
    end else begin
      cnt    <= cnt + STEP;
    end
  end

  // One-entry symbol buffer: drained at a boundary, filled by an accept that
  // does not coincide with a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_i    <= '0;
      buf_q    <= '0;
    end else if (boundary && buf_full) begin
      buf_full <= 1'b0;
    end else if (accept && !boundary) begin
      buf_full <= 1'b1;
      buf_i    <= I_1M;
      buf_q    <= Q_1M;
    end
  end

  // ---- stage p0: current symbol register ----
  // Holds the symbol being transmitted for the remainder of its period.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      sym_i_p0 <= '0;
      sym_q_p0 <= '0;
    end else if (boundary) begin
      sym_i_p0 <= load_i;
      sym_q_p0 <= load_q;
    end
  end

  // ---- stage p1: registered sample outputs ----
  // Strobe sample carries the new symbol directly; later samples either hold
  // the symbol or are zero-stuffed.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      I_32M      <= '0;
      Q_32M      <= '0;
      sym_strobe <= 1'b0;
    end else begin
      sym_strobe <= boundary;
      if (boundary) begin
        I_32M <= load_i;
        Q_32M <= load_q;
      end else if (ZERO_STUFF) begin
        I_32M <= '0;
        Q_32M <= '0;
      end else begin
        I_32M <= sym_i_p0;
        Q_32M <= sym_q_p0;
      end
    end
  end

  // Sticky underflow; a new underflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (uf_set) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_symbol_upsampler.sv
// Self-checking bench for symbol_upsampler: table of rate configurations,
// directed corner sequences and a randomized phase, all compared cycle by
// cycle against a behavioural model kept here.
module tb_symbol_upsampler;

  localparam int NOM  = 8192;
  localparam int STEP = 256;

  logic               clk = 1'b0;
  logic               rst, en, zs, clr, valid;
  logic signed [15:0] rate_off, i_in, q_in;
  logic               ready, strobe, uf;
  logic signed [15:0] i_out, q_out;

  always #5 clk = ~clk;

  symbol_upsampler #(.WIDTH(16), .OSR_LOG2(5)) dut (
    .clk(clk), .rst(rst), .en(en), .ZERO_STUFF(zs), .RATE_OFFSET(rate_off),
    .clr_underflow(clr), .I_1M(i_in), .Q_1M(q_in), .sym_valid(valid),
    .sym_ready(ready), .I_32M(i_out), .Q_32M(q_out), .sym_strobe(strobe),
    .underflow(uf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int strobes[$];

  // Behavioural model state
  int   m_cnt = NOM;
  int   m_per = NOM;
  int   fifo_i[$];
  int   fifo_q[$];
  int   m_si = 0, m_sq = 0;
  int   e_i = 0, e_q = 0;
  bit   e_str = 0, e_uf = 0;
  bit   m_acc = 0;

  typedef struct {
    logic zs;
    int   off;
    int   sp_a;
    int   sp_b;
  } rate_vec_t;
  rate_vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampp(input int off);
    int p;
    p = NOM + off;
    if (p < NOM / 2) return NOM / 2;
    if (p > NOM * 3 / 2) return NOM * 3 / 2;
    return p;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int ni, nq;
    bit fire, starve;
    m_acc = valid && (fifo_i.size() == 0) && !rst;
    if (rst) begin
      m_cnt = NOM; m_per = NOM;
      fifo_i.delete(); fifo_q.delete();
      m_si = 0; m_sq = 0; e_i = 0; e_q = 0; e_str = 0; e_uf = 0;
      return;
    end
    if (!en) begin
      if (m_acc) begin fifo_i.push_back(int'(i_in)); fifo_q.push_back(int'(q_in)); end
      m_cnt = NOM; m_per = NOM;
      m_si = 0; m_sq = 0; e_i = 0; e_q = 0; e_str = 0;
      if (clr) e_uf = 0;
      return;
    end
    fire   = (m_cnt >= m_per);
    starve = 0;
    if (fire) begin
      if (fifo_i.size() > 0) begin
        ni = fifo_i.pop_front(); nq = fifo_q.pop_front();
      end else if (m_acc) begin
        ni = int'(i_in); nq = int'(q_in);
      end else begin
        ni = 0; nq = 0; starve = 1;
      end
      m_cnt = m_cnt - m_per + STEP;
      m_per = clampp(int'(rate_off));
      m_si = ni; m_sq = nq; e_i = ni; e_q = nq; e_str = 1;
    end else begin
      if (m_acc) begin fifo_i.push_back(int'(i_in)); fifo_q.push_back(int'(q_in)); end
      m_cnt = m_cnt + STEP;
      e_str = 0;
      e_i = zs ? 0 : m_si;
      e_q = zs ? 0 : m_sq;
    end
    if (starve) e_uf = 1;
    else if (clr) e_uf = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("I_32M", int'(i_out), e_i);
    chk("Q_32M", int'(q_out), e_q);
    chk("sym_strobe", int'(strobe), int'(e_str));
    chk("underflow", int'(uf), int'(e_uf));
    chk("sym_ready", int'(ready), (fifo_i.size() == 0 && !rst) ? 1 : 0);
    if (strobe) strobes.push_back(cyc);
  endtask

  // Run until the coming cycle is a boundary (bounded).
  task automatic wait_bnd();
    int k;
    k = 0;
    while (!(m_cnt >= m_per) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("wait_boundary", 0, 1);
  endtask

  task automatic rand_data();
    logic [31:0] r;
    r = $urandom;
    i_in = r[15:0];
    q_in = r[31:16];
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int changes, last, n, nz, k, tmpo, prev_sp;
    int offs[8];
    logic [31:0] r;

    vecs[0] = '{1'b0, 0, 32, 32};
    vecs[1] = '{1'b0, 256, 33, 33};
    vecs[2] = '{1'b0, -256, 31, 31};
    vecs[3] = '{1'b0, -128, 32, 31};
    vecs[4] = '{1'b0, 16384, 48, 48};
    vecs[5] = '{1'b0, -16384, 16, 16};
    vecs[6] = '{1'b1, 0, 32, 32};
    vecs[7] = '{1'b0, 32767, 48, 48};
    offs = '{0, 256, -256, -128, 100, -77, 16384, -20000};

    rst = 1; en = 0; zs = 0; clr = 0; valid = 0;
    rate_off = 0; i_in = 0; q_in = 0;

    // Reset state
    repeat (4) tick();
    chk("reset_I", int'(i_out), 0);
    chk("reset_strobe", int'(strobe), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_uf", int'(uf), 0);

    // Nominal rate with preloaded symbol
    rst = 0; valid = 1; i_in = 1000; q_in = -1000;
    tick();
    chk("preload_ready", int'(ready), 0);
    i_in = 1001; q_in = -1001; en = 1;
    strobes.delete();
    tick();
    chk("first_strobe", int'(strobe), 1);
    chk("first_I", int'(i_out), 1000);
    chk("first_Q", int'(q_out), -1000);
    changes = 0;
    last = int'(i_out);
    repeat (160) begin
      tick();
      if (m_acc) begin i_in = i_in + 1; q_in = q_in - 1; end
      if (!strobe && int'(i_out) != last) changes++;
      last = int'(i_out);
    end
    chk("hold_changes", changes, 0);
    chk("nominal_strobes", strobes.size(), 6);
    chk("nominal_uf", int'(uf), 0);

    // Underflow: starve the input
    valid = 0;
    strobes.delete();
    repeat (70) tick();
    chk("uf_strobes_continue", (strobes.size() >= 2) ? 1 : 0, 1);
    chk("uf_set", int'(uf), 1);
    chk("uf_sticky_I", int'(i_out), 0);
    if (m_cnt >= m_per) tick();
    clr = 1;
    tick();
    clr = 0;
    chk("uf_clear", int'(uf), 0);
    wait_bnd();
    clr = 1;
    tick();
    clr = 0;
    chk("uf_set_beats_clr", int'(uf), 1);
    chk("uf_zero_strobe", int'(strobe), 1);

    // Bypass on an empty buffer exactly at the boundary
    clr = 1;
    tick();
    clr = 0;
    wait_bnd();
    valid = 1; i_in = 777; q_in = -777;
    tick();
    valid = 0;
    chk("bypass_strobe", int'(strobe), 1);
    chk("bypass_I", int'(i_out), 777);
    chk("bypass_Q", int'(q_out), -777);
    chk("bypass_no_uf", int'(uf), 0);

    // Backpressure while the buffer is full
    tick();
    valid = 1; i_in = 321; q_in = -321;
    tick();
    valid = 0;
    chk("bp_ready_full", int'(ready), 0);
    wait_bnd();
    chk("bp_ready_before_bnd", int'(ready), 0);
    tick();
    chk("bp_ready_after_bnd", int'(ready), 1);
    chk("bp_I", int'(i_out), 321);

    // Reset at sample 10 of a symbol
    valid = 1; i_in = 1234; q_in = -1234;
    k = 0;
    tick();
    while (!strobe && k < 100) begin tick(); k++; end
    if (k >= 100) chk("wait_strobe", 0, 1);
    repeat (10) tick();
    chk("pre_reset_nonzero", (i_out != 0) ? 1 : 0, 1);
    rst = 1;
    repeat (3) begin
      tick();
      chk("rst_mid_I", int'(i_out), 0);
      chk("rst_mid_ready", int'(ready), 0);
    end
    rst = 0; en = 0;
    tick();
    chk("post_reset_idle_strobe", int'(strobe), 0);
    en = 1;
    tick();
    chk("post_reset_first_strobe", int'(strobe), 1);

    // Enable dropped mid-symbol
    repeat (10) tick();
    en = 0;
    tick();
    chk("en_drop_I", int'(i_out), 0);
    chk("en_drop_strobe", int'(strobe), 0);
    en = 1;

    // Table-driven rate / zero-stuff configurations
    for (int v = 0; v < 8; v++) begin
      rst = 1; tick(); tick();
      rst = 0; en = 1; zs = vecs[v].zs;
      tmpo = vecs[v].off;
      rate_off = tmpo[15:0];
      valid = 1;
      strobes.delete();
      k = 0;
      while (strobes.size() < 8 && k < 600) begin
        rand_data();
        tick();
        k++;
      end
      if (strobes.size() < 8) begin
        chk("rate_strobes", strobes.size(), 8);
      end else begin
        for (int s = 1; s < 7; s++) begin
          prev_sp = (s % 2 == 1) ? vecs[v].sp_a : vecs[v].sp_b;
          chk("rate_spacing", strobes[s] - strobes[s-1], prev_sp);
        end
      end
      chk("rate_no_uf", int'(uf), 0);
    end

    // Zero-stuff with incrementing symbols
    rst = 1; tick();
    rst = 0; zs = 1; en = 1; valid = 1; rate_off = 0;
    i_in = 500; q_in = -500;
    n = 0; nz = 0;
    repeat (130) begin
      tick();
      if (strobe) begin
        chk("zs_symbol", int'(i_out), 500 + 100 * n);
        n++;
      end else if (i_out != 0 || q_out != 0) begin
        nz++;
      end
      if (m_acc) begin i_in = i_in + 100; q_in = q_in - 100; end
    end
    chk("zs_nonzero_fill", nz, 0);
    chk("zs_strobe_count", n, 5);

    // Randomized phase against the model
    zs = 0;
    for (int c = 0; c < 2500; c++) begin
      r = $urandom;
      rst = (r[6:0] == 7'd0);
      if (en) begin
        if (r[13:8] == 6'd0) en = 0;
      end else begin
        if (r[10:8] == 3'd0) en = 1;
      end
      if (r[21:14] < 8'd2) zs = ~zs;
      valid = (r[24:22] != 3'd0);
      clr = (r[28:25] == 4'd0);
      if (r[31:29] == 3'd0 && ($urandom % 40) == 0) rate_off = 16'(offs[$urandom % 8]);
      rand_data();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/symbol_upsampler.md
Name: symbol_upsampler

Overview:
- Transmit-side counterpart of the receive timing recovery. Accepts 1.024M I/Q symbols over a valid/ready handshake and emits a 32.768M sample stream for the pulse-shaping / DAC path.
- Symbol boundaries come from the same fixed-point phase-accumulator scheme the receiver uses: accumulate a fixed step, fire on reaching the period.
- A programmable period offset lets the bench inject a controlled symbol-rate error, so the RX Gardner loop can be exercised end to end.

Parameters:
- WIDTH, 16, sample width and phase-accumulator width; must be >= 8.
- OSR_LOG2, 5, log2 of nominal samples per symbol (32).

Ports:
- clk  input  1  32.768M clock
- rst  input  1  synchronous, active-high reset
- en  input  1  run enable; low = idle, zero output
- ZERO_STUFF  input  1  1 = symbol value on strobe sample only, zeros otherwise; 0 = hold the symbol for its whole period
- RATE_OFFSET  input  signed WIDTH  added to the nominal period (units of the accumulator LSB)
- clr_underflow  input  1  clears the sticky underflow flag
- I_1M  input  signed WIDTH  symbol I
- Q_1M  input  signed WIDTH  symbol Q
- sym_valid  input  1  symbol offered
- sym_ready  output  1  symbol buffer can accept
- I_32M  output reg signed WIDTH  sample I
- Q_32M  output reg signed WIDTH  sample Q
- sym_strobe  output reg 1  high on the first sample of each symbol
- underflow  output reg 1  sticky; a boundary occurred with no symbol available

Behaviour:
- Constants:
  - PERIOD_NOM = 2^(WIDTH-3), which is 8192 at WIDTH=16.
  - STEP = PERIOD_NOM >> OSR_LOG2, which is 256.
- Width rules:
  - cnt and period are WIDTH+1 bits, so there is no overflow.
  - At each boundary, period <= PERIOD_NOM + RATE_OFFSET, clamped to [PERIOD_NOM/2, PERIOD_NOM*3/2].
- Symbol buffer:
  - One entry with flag buf_full.
  - sym_ready = !buf_full && !rst.
  - Accept when sym_valid && sym_ready.
- States: IDLE, RUN.
- Reset, and while en=0 (IDLE):
  - I_32M = Q_32M = 0, sym_strobe = 0, cnt = PERIOD_NOM, period = PERIOD_NOM.
  - The output symbol register is cleared.
  - Reset also clears buf_full and underflow.
  - In IDLE, the buffer still accepts symbols.
- IDLE->RUN when en=1. RUN->IDLE when en=0; the change takes effect on the next cycle and any partial symbol is abandoned.
- RUN, per cycle:
  - Boundary cycle is when cnt >= period.
  - On a boundary: cnt <= cnt - period + STEP. Otherwise: cnt <= cnt + STEP.
  - Because cnt starts at PERIOD_NOM, the first RUN cycle is a boundary.
  - With RATE_OFFSET=0, boundaries are exactly 32 cycles apart. A +STEP offset gives 33, and -STEP gives 31.
- Boundary in cycle t:
  - If buf_full: the symbol register loads from the buffer and buf_full clears. A new accept is possible from t+1.
  - If the buffer is empty but an accept occurs in t: the accepted symbol bypasses straight into the symbol register. This is not an underflow.
  - Otherwise: the symbol register loads 0 and underflow is set.
- Outputs, registered, one cycle after the boundary:
  - sym_strobe=1 for exactly the cycle t+1.
  - I_32M/Q_32M equal the new symbol in t+1.
  - For the rest of the period, outputs are the symbol (ZERO_STUFF=0) or 0 (ZERO_STUFF=1).
  - ZERO_STUFF is sampled every cycle.
- Accept with no boundary: the buffer loads and buf_full is set.
- underflow: set has priority over clr_underflow in the same cycle.
- rst mid-symbol: all state returns to its reset value on the next edge; the buffered symbol is discarded.

Test Plan:
- Nominal rate: rst 4 cycles, preload symbol (1000,-1000), en=1, ZERO_STUFF=0, keep sym_valid high with an incrementing I -> sym_strobe every 32 cycles; I_32M constant for 32 samples; first strobe 1 cycle after en rises; no underflow.
- Zero-stuff: ZERO_STUFF=1, symbols 500,600,... -> each strobe sample equals the symbol and the other 31 samples are 0.
- Rate offset:
  - RATE_OFFSET=+256 -> strobe spacing 33 after the first boundary.
  - RATE_OFFSET=-128 -> spacing alternates 32/31, averaging 31.5.
  - RATE_OFFSET=+16384 -> clamped to a spacing of 48.
- Underflow:
  - Stop sym_valid -> next symbol outputs 0 with strobe still pulsing; underflow=1 stays set.
  - clr_underflow clears it.
  - Clear coinciding with a new underflow -> underflow stays 1.
- Bypass and backpressure:
  - Empty buffer with sym_valid asserted exactly on the boundary cycle -> symbol appears at t+1 with no underflow.
  - With the buffer full, sym_ready=0 until the boundary, then 1.
- Reset/enable mid-symbol:
  - rst asserted at sample 10 of a symbol -> outputs 0 and sym_ready=0 during reset.
  - After reset, the first strobe comes 1 cycle after en.
  - en dropped mid-symbol -> outputs 0 next cycle.
